shift_add_mult: RTL

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/shift_add_mult.sv | 134 +++++++++++++
 1 files changed

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add unsigned multiplier with an IDLE/CALC/DONE control FSM.
// Optional macro EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH:0]       chain;
  logic [WIDTH-1:0]     sum;
  logic                 add_c;
  logic [WIDTH-1:0]     add_s;
  logic [WIDTH-1:0]     a_sh;
  logic [WIDTH-1:0]     q_sh;
  logic [CW-1:0]        cnt_dec;
  logic                 finish;
  logic [2*WIDTH-1:0]   result;

  // Ripple-carry chain of full-adder cells, carry-in tied to 0.
  always_comb begin
    chain    = '0;
    sum      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = a_q[i] ^ m_q[i] ^ chain[i];
      chain[i+1] = (a_q[i] & m_q[i]) | (a_q[i] & chain[i]) | (m_q[i] & chain[i]);
    end
  end

  // The carry only lives between the add and the shift, so it is a net rather
  // than a register; it is shifted into the top of A every iteration.
  assign add_c   = q_q[0] ? chain[WIDTH] : 1'b0;
  assign add_s   = q_q[0] ? sum : a_q;
  assign a_sh    = {add_c, add_s[WIDTH-1:1]};
  assign q_sh    = {add_s[0], q_q[WIDTH-1:1]};
  assign cnt_dec = cnt_q - 1'b1;

`ifdef EARLY_TERM_EN
  logic rest_zero;

  // Unprocessed multiplier bits sit in the low cnt_dec bits of Q after the shift.
  always_comb begin
    rest_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i < int'(cnt_dec)) && q_sh[i]) rest_zero = 1'b0;
    end
  end

  assign finish = (cnt_dec == '0) || rest_zero;
  assign result = {a_sh, q_sh} >> cnt_dec;
`else
  assign finish = (cnt_dec == '0);
  assign result = {a_sh, q_sh};
`endif

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          cnt_d   = CW'(WIDTH);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        a_d   = a_sh;
        q_d   = q_sh;
        cnt_d = cnt_dec;
        if (finish) begin
          product_d = result;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == S_CALC);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule
